// File: rtl/fifo_wrctl.sv
// Write-side controller of the dual-clock FIFO: RAM write port,
// Gray write-pointer publication and read-pointer synchronization.
module fifo_wrctl #(
  parameter int ADDRBIT = 9,
  parameter int WIDTH   = 32,
  parameter int AFULL   = 2**ADDRBIT - 4
) (
  input  logic               wrclk,
  input  logic               wrst_,
  input  logic               push,
  input  logic [WIDTH-1:0]   din,
  input  logic               ovf_clr,
  input  logic [ADDRBIT:0]   rptr_gray,
  output logic               full,
  output logic               afull,
  output logic [ADDRBIT:0]   level,
  output logic               ovf,
  output logic [ADDRBIT-1:0] wa,
  output logic               we,
  output logic [WIDTH-1:0]   di,
  output logic [ADDRBIT:0]   wptr_gray
);

  localparam logic [ADDRBIT:0] ONE = 1;
  localparam logic [ADDRBIT:0] DEPTH_P = ONE << ADDRBIT;
  localparam logic [ADDRBIT:0] AF = (ADDRBIT+1)'(AFULL);

  function automatic logic [ADDRBIT:0] g2b(input logic [ADDRBIT:0] g);
    logic [ADDRBIT:0] b;
    b[ADDRBIT] = g[ADDRBIT];
    for (int i = ADDRBIT - 1; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [ADDRBIT:0] wbin;
  logic [ADDRBIT:0] wbin_nx;
  logic [ADDRBIT:0] rsync1;
  logic [ADDRBIT:0] rsync2;
  logic [ADDRBIT:0] rbin;
  logic [ADDRBIT:0] wg1;
  logic [ADDRBIT:0] level_nx;
  logic             accept;

  assign accept   = push & ~full;
  assign wbin_nx  = accept ? wbin + ONE : wbin;
  assign rbin     = g2b(rsync2);
  assign level_nx = wbin_nx - rbin;

  always_ff @(posedge wrclk or negedge wrst_) begin
    if (!wrst_) begin
      wbin   <= '0;
      rsync1 <= '0;
      rsync2 <= '0;
      level  <= '0;
      full   <= 1'b0;
      afull  <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      wbin   <= wbin_nx;
      rsync1 <= rptr_gray;
      rsync2 <= rsync1;
      level  <= level_nx;
      full   <= level_nx == DEPTH_P;
      afull  <= level_nx >= AF;
      // a fresh overflow wins over a simultaneous clear
      ovf    <= (push & full) | (ovf & ~ovf_clr);
    end
  end

  always_ff @(posedge wrclk or negedge wrst_) begin
    if (!wrst_) begin
      wa <= '0;
      we <= 1'b0;
      di <= '0;
    end else begin
      we <= accept;
      if (accept) begin
        wa <= wbin[ADDRBIT-1:0];
        di <= din;
      end
    end
  end

  // two stages so the pointer trails the RAM commit
  always_ff @(posedge wrclk or negedge wrst_) begin
    if (!wrst_) begin
      wg1       <= '0;
      wptr_gray <= '0;
    end else begin
      wg1       <= wbin ^ (wbin >> 1);
      wptr_gray <= wg1;
    end
  end

endmodule
